// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared encodings for the memory responder (access modes, FSM, lanes)
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [1:0] MEM_WORD  = 2'b00;
  localparam logic [1:0] MEM_SBYTE = 2'b01;
  localparam logic [1:0] MEM_UBYTE = 2'b10;
  localparam logic [1:0] MEM_RSVD  = 2'b11;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/byte_lane_unit.sv
// ============================================================================
// byte_lane_unit : extracts/extends a byte lane for reads, merges a byte for RMW
// Revision: 1.0
// ============================================================================
`default_nettype none

module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_mode,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_rd_fmt,
  output logic [31:0] o_merged
);

  logic [7:0] w_lane_byte;

  // Little-endian: lane 0 is bits [7:0]
  always_comb begin
    w_lane_byte = i_word[7:0];
    o_merged    = i_word;
    case (i_lane)
      LANE_B0: begin w_lane_byte = i_word[7:0];   o_merged[7:0]   = i_byte; end
      LANE_B1: begin w_lane_byte = i_word[15:8];  o_merged[15:8]  = i_byte; end
      LANE_B2: begin w_lane_byte = i_word[23:16]; o_merged[23:16] = i_byte; end
      LANE_B3: begin w_lane_byte = i_word[31:24]; o_merged[31:24] = i_byte; end
      default: ;
    endcase
  end

  always_comb begin
    o_rd_fmt = i_word;
    case (i_mode)
      MEM_SBYTE: o_rd_fmt = {{24{w_lane_byte[7]}}, w_lane_byte};
      MEM_UBYTE: o_rd_fmt = {24'h000000, w_lane_byte};
      default:   o_rd_fmt = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : single-request memory responder over a word RAM, with byte
//                 reads (sign/zero extended) and read-modify-write byte stores
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemWrite,
  input  logic [1:0]  MemMode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   w_in_idx;
  logic                w_in_err;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_lane;
  logic [1:0]          r_mode;
  logic [7:0]          r_wbyte;
  logic [31:0]         r_word;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [31:0]         w_ram_wdata;
  logic [31:0]         w_fmt;
  logic [31:0]         w_merged;

  logic [31:0]         r_mem [DEPTH];

  assign w_in_idx = addr[ADDR_W+1:2];
  assign w_in_err = (MemMode == MEM_RSVD)
                  | ((MemMode == MEM_WORD) & (addr[1:0] != 2'b00))
                  | (|addr[31:ADDR_W+2]);

  byte_lane_unit u_lane (
    .i_word   (r_word),
    .i_lane   (r_lane),
    .i_mode   (r_mode),
    .i_byte   (r_wbyte),
    .o_rd_fmt (w_fmt),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // RAM writes are gated by reset so an aborted operation never lands
  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_idx;
    w_ram_wdata = w_merged;
    case (r_state)
      ST_IDLE: begin
        req_ready   = 1'b1;
        w_ram_addr  = w_in_idx;
        w_ram_wdata = wdata;
        if (req_valid) begin
          if (w_in_err) begin
            w_next = ST_RESP;
          end else if (!MemWrite) begin
            w_next = ST_READ;
          end else if (MemMode == MEM_WORD) begin
            w_next   = ST_RESP;
            w_ram_we = reset;
          end else begin
            w_next = ST_RMW_RD;
          end
        end
      end
      ST_READ:   w_next = ST_RESP;
      ST_RMW_RD: w_next = ST_RMW_WR;
      ST_RMW_WR: begin
        w_ram_we = reset;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Synchronous-read port follows the incoming index in IDLE, the latched one after
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
    r_word <= r_mem[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx   <= '0;
      r_lane  <= 2'b00;
      r_mode  <= MEM_WORD;
      r_wbyte <= 8'h00;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_idx   <= w_in_idx;
        r_lane  <= addr[1:0];
        r_mode  <= MemMode;
        r_wbyte <= wdata[7:0];
      end
      if (r_state != ST_RESP && w_next == ST_RESP) begin
        r_rdata <= (r_state == ST_READ) ? w_fmt : 32'h0;
        r_err   <= (r_state == ST_IDLE) ? w_in_err : 1'b0;
      end
    end
  end

  assign rdata = r_rdata;
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : directed vector table plus reset-abort and held-valid cases
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        MemWrite;
  logic [1:0]  MemMode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  int total = 0;
  int bad   = 0;
  int acc_cnt  = 0;
  int resp_cnt = 0;

  mem_responder #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .MemWrite   (MemWrite),
    .MemMode    (MemMode),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && req_valid && req_ready) acc_cnt++;
    if (reset && resp_valid) resp_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[20];
  int   nvec;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] mode, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; MemWrite = we; MemMode = mode; addr = a; wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; rd = rdata; er = err; break; end
    end
  endtask

  task automatic add(input logic we, input logic [1:0] mode, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] erd, input logic eer,
                     input int elat);
    vecs[nvec] = '{we, mode, a, wd, erd, eer, elat};
    nvec++;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          r0;
    int          a0;
    int          n;

    reset = 1'b0; req_valid = 1'b0; MemWrite = 1'b0; MemMode = 2'b00;
    addr = 32'h0; wdata = 32'h0;
    nvec = 0;

    add(1, 2'b00, 32'h10,   32'hDEADBEEF, 32'h00000000, 0, 1);
    add(0, 2'b00, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2);
    add(1, 2'b00, 32'h20,   32'h80FF7F01, 32'h00000000, 0, 1);
    add(0, 2'b01, 32'h20,   32'h0,        32'h00000001, 0, 2);
    add(0, 2'b01, 32'h23,   32'h0,        32'hFFFFFF80, 0, 2);
    add(0, 2'b10, 32'h22,   32'h0,        32'h000000FF, 0, 2);
    add(0, 2'b10, 32'h21,   32'h0,        32'h0000007F, 0, 2);
    add(0, 2'b01, 32'h22,   32'h0,        32'hFFFFFFFF, 0, 2);
    add(1, 2'b00, 32'h30,   32'h11223344, 32'h00000000, 0, 1);
    add(1, 2'b01, 32'h31,   32'hFFFFFFAB, 32'h00000000, 0, 3);
    add(0, 2'b00, 32'h30,   32'h0,        32'h1122AB44, 0, 2);
    add(0, 2'b00, 32'h32,   32'h0,        32'h00000000, 1, 1);
    add(0, 2'b11, 32'h30,   32'h0,        32'h00000000, 1, 1);
    add(1, 2'b00, 32'h0,    32'hCAFEF00D, 32'h00000000, 0, 1);
    add(0, 2'b00, 32'h1000, 32'h0,        32'h00000000, 1, 1);
    add(1, 2'b00, 32'h1000, 32'h12345678, 32'h00000000, 1, 1);
    add(1, 2'b00, 32'h32,   32'h00000000, 32'h00000000, 1, 1);
    add(1, 2'b11, 32'h30,   32'h00000000, 32'h00000000, 1, 1);
    add(0, 2'b00, 32'h0,    32'h0,        32'hCAFEF00D, 0, 2);
    add(1, 2'b10, 32'h33,   32'h0000005A, 32'h00000000, 0, 3);

    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      do_req(vecs[i].we, vecs[i].mode, vecs[i].a, vecs[i].wd, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), {31'h0, resp_valid}, 32'h0);
      check($sformatf("v%0d_hold", i), rdata, vecs[i].exp_rd);
    end

    do_req(0, 2'b00, 32'h30, 32'h0, rd, er, lat);
    check("ubyte_store_word", rd, 32'h5A22AB44);

    // Reset asserted while the byte store sits in RMW_WR
    do_req(1, 2'b00, 32'h40, 32'h55555555, rd, er, lat);
    check("abort_prep_lat", lat, 1);
    @(negedge clk);
    check("abort_ready_pre", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; MemWrite = 1'b1; MemMode = 2'b01; addr = 32'h40; wdata = 32'h000000AA;
    r0 = resp_cnt;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_resp", resp_cnt - r0, 0);
    do_req(0, 2'b00, 32'h40, 32'h0, rd, er, lat);
    check("abort_word_kept", rd, 32'h55555555);
    check("abort_read_lat", lat, 2);

    // req_valid held high across the busy cycles of a read
    @(negedge clk);
    a0 = acc_cnt; r0 = resp_cnt;
    req_valid = 1'b1; MemWrite = 1'b0; MemMode = 2'b00; addr = 32'h10; wdata = 32'h0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b0;
    check("held_lat", n, 2);
    check("held_rdata", rdata, 32'hDEADBEEF);
    repeat (4) @(negedge clk);
    check("held_accepts", acc_cnt - a0, 1);
    check("held_resps", resp_cnt - r0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
